activation_unit: RTL and testbench

ACTIVATION_UNIT -- requirements
Module: activation_unit

---
 rtl/activation_unit.sv | 119 +++++++++++
 tb/tb_activation_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_unit.sv
// activation_unit: per-sample activation (pass / ReLU / clamp / leaky) with a
// vector index counter and a 2-entry output FIFO.
// Optional feature macro: ACTIVATION_STATS_EN adds clip_count / stats_clear.
module activation_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int WEIGHT_AMOUNT = 4,
  parameter int CLAMP_MAX     = 6,
  parameter int LEAK_SHIFT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            mode,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic [DATA_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef ACTIVATION_STATS_EN
  ,
  output logic [DATA_WIDTH-1:0] clip_count,
  input  logic                  stats_clear
`endif
);

  localparam logic signed [DATA_WIDTH-1:0] CLAMP_V  = DATA_WIDTH'(CLAMP_MAX);
  localparam logic        [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(WEIGHT_AMOUNT - 1);

  logic [1:0]                   count;
  logic                         rd_ptr;
  logic                         wr_ptr;
  logic [DATA_WIDTH-1:0]        mem_value [2];
  logic [DATA_WIDTH-1:0]        mem_index [2];
  logic                         mem_last  [2];
  logic [DATA_WIDTH-1:0]        idx_q;
  logic [1:0]                   mode_q;
  logic [1:0]                   mode_eff;
  logic signed [DATA_WIDTH-1:0] s_in;
  logic signed [DATA_WIDTH-1:0] act;
  logic                         push;
  logic                         pop;
  logic                         is_last;

  assign s_in      = in_value;
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign is_last   = (idx_q == LAST_IDX);
  // An index-0 sample uses the live mode; the rest of the vector uses the latched one.
  assign mode_eff  = (idx_q == '0) ? mode : mode_q;

  assign out_value = mem_value[rd_ptr];
  assign out_index = mem_index[rd_ptr];
  assign out_last  = mem_last[rd_ptr];

  // Activation function selected by the effective mode.
  always_comb begin
    act = s_in;
    case (mode_eff)
      2'd1: if (s_in < 0) act = '0;
      2'd2: begin
        if (s_in < 0)            act = '0;
        else if (s_in > CLAMP_V) act = CLAMP_V;
      end
      2'd3: if (s_in < 0) act = s_in >>> LEAK_SHIFT;
      default: act = s_in;
    endcase
  end

  // Index counter and per-vector mode latch advance only on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      mode_q <= 2'd1;
    end else if (push) begin
      idx_q <= is_last ? '0 : idx_q + 1'b1;
      if (idx_q == '0) mode_q <= mode;
    end
  end

  // Two-entry FIFO: pointers, occupancy and storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_value[i] <= '0;
        mem_index[i] <= '0;
        mem_last[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_value[wr_ptr] <= act;
        mem_index[wr_ptr] <= idx_q;
        mem_last[wr_ptr]  <= is_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef ACTIVATION_STATS_EN
  // Saturating count of accepted samples altered by the activation.
  always_ff @(posedge clk) begin
    if (rst || stats_clear)                         clip_count <= '0;
    else if (push && (act != s_in) && (clip_count != '1)) clip_count <= clip_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_activation_unit.sv
// Directed self-checking bench for activation_unit (default parameters).
module tb_activation_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_value;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [31:0] out_value;
  logic [31:0] out_index;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
`ifdef ACTIVATION_STATS_EN
  logic [31:0] clip_count;
  logic        stats_clear;
`endif

  int pass_count  = 0;
  int check_count = 0;

  activation_unit dut (
    .clk(clk), .rst(rst),
    .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode),
    .out_value(out_value), .out_index(out_index), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef ACTIVATION_STATS_EN
    , .clip_count(clip_count), .stats_clear(stats_clear)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_value = '0; mode = 2'd0; out_ready = 1'b0;
`ifdef ACTIVATION_STATS_EN
    stats_clear = 1'b0;
`endif
    tick(); tick();
    check_count++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid);
    else pass_count++;
    check_count++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready);
    else pass_count++;
    check_count++;
    if (out_value !== 32'd0 || out_index !== 32'd0 || out_last !== 1'b0)
      $display("FAIL reset_outputs got value=%0d index=%0d last=%0b want 0 0 0",
               out_value, out_index, out_last);
    else pass_count++;
    rst = 1'b0;
    tick();
  endtask

  // Streaming with out_ready=1: every accepted word appears one cycle later.
  task automatic test_relu;
    int vin [4] = '{5, -3, 7, -1};
    int vexp[4] = '{5, 0, 7, 0};
    mode = 2'd1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_value = 32'(vin[i]); in_valid = 1'b1;
      tick();
      check_count++;
      if (out_valid !== 1'b1 || out_value !== 32'(vexp[i]) || out_index !== 32'(i) ||
          out_last !== (i == 3))
        $display("FAIL relu_%0d got v=%0b val=%0d idx=%0d last=%0b want 1 %0d %0d %0b",
                 i, out_valid, $signed(out_value), out_index, out_last, vexp[i], i, (i == 3));
      else pass_count++;
    end
    in_valid = 1'b0;
    tick();
    check_count++;
    if (out_valid !== 1'b0) $display("FAIL relu_drain got out_valid=%0b want 0", out_valid);
    else pass_count++;
  endtask

  task automatic test_clamp_leaky;
    int cin [4] = '{9, -2, 6, 3};
    int cexp[4] = '{6, 0, 6, 3};
    int lin [4] = '{-16, -1, 8, -8};
    int lexp[4] = '{-2, -1, 8, -1};
    out_ready = 1'b1;
    mode = 2'd2;
    for (int i = 0; i < 4; i++) begin
      in_value = 32'(cin[i]); in_valid = 1'b1;
      tick();
      check_count++;
      if (out_valid !== 1'b1 || out_value !== 32'(cexp[i]) || out_index !== 32'(i))
        $display("FAIL clamp_%0d got v=%0b val=%0d idx=%0d want 1 %0d %0d",
                 i, out_valid, $signed(out_value), out_index, cexp[i], i);
      else pass_count++;
    end
    mode = 2'd3;
    for (int i = 0; i < 4; i++) begin
      in_value = 32'(lin[i]); in_valid = 1'b1;
      tick();
      check_count++;
      if (out_valid !== 1'b1 || out_value !== 32'(lexp[i]) || out_index !== 32'(i) ||
          out_last !== (i == 3))
        $display("FAIL leaky_%0d got v=%0b val=%0d idx=%0d last=%0b want 1 %0d %0d %0b",
                 i, out_valid, $signed(out_value), out_index, out_last, lexp[i], i, (i == 3));
      else pass_count++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    mode = 2'd0; out_ready = 1'b0;
    in_value = 32'd10; in_valid = 1'b1;
    tick();
    check_count++;
    if (out_valid !== 1'b1 || out_value !== 32'd10 || out_index !== 32'd0 || in_ready !== 1'b1)
      $display("FAIL bp_first got v=%0b val=%0d idx=%0d rdy=%0b want 1 10 0 1",
               out_valid, out_value, out_index, in_ready);
    else pass_count++;
    in_value = 32'd20;
    tick();
    check_count++;
    if (in_ready !== 1'b0 || out_value !== 32'd10)
      $display("FAIL bp_full got rdy=%0b val=%0d want 0 10", in_ready, out_value);
    else pass_count++;
    in_value = 32'd30;
    tick();
    check_count++;
    if (in_ready !== 1'b0 || out_value !== 32'd10 || out_index !== 32'd0 || out_valid !== 1'b1)
      $display("FAIL bp_frozen got rdy=%0b val=%0d idx=%0d v=%0b want 0 10 0 1",
               in_ready, out_value, out_index, out_valid);
    else pass_count++;
    out_ready = 1'b1;
    tick();
    check_count++;
    if (out_value !== 32'd20 || out_index !== 32'd1 || in_ready !== 1'b1)
      $display("FAIL bp_second got val=%0d idx=%0d rdy=%0b want 20 1 1",
               out_value, out_index, in_ready);
    else pass_count++;
    tick();
    check_count++;
    if (out_valid !== 1'b1 || out_value !== 32'd30 || out_index !== 32'd2)
      $display("FAIL bp_third got v=%0b val=%0d idx=%0d want 1 30 2",
               out_valid, out_value, out_index);
    else pass_count++;
    in_valid = 1'b0;
    tick();
    check_count++;
    if (out_valid !== 1'b0) $display("FAIL bp_drain got out_valid=%0b want 0", out_valid);
    else pass_count++;
    in_value = 32'd1; in_valid = 1'b1;
    tick();
    check_count++;
    if (out_index !== 32'd3 || out_last !== 1'b1)
      $display("FAIL bp_wrap got idx=%0d last=%0b want 3 1", out_index, out_last);
    else pass_count++;
    in_valid = 1'b0;
    tick();
  endtask

  // Mode changes mid-vector are ignored until the next index 0.
  task automatic test_mode_switch;
    int vin [5] = '{1, 2, -4, -4, -4};
    int vexp[5] = '{1, 2, 0, 0, -4};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mode = (i < 2) ? 2'd1 : 2'd0;
      in_value = 32'(vin[i]); in_valid = 1'b1;
      tick();
      check_count++;
      if (out_value !== 32'(vexp[i]) || out_index !== 32'(i % 4))
        $display("FAIL modesw_%0d got val=%0d idx=%0d want %0d %0d",
                 i, $signed(out_value), out_index, vexp[i], i % 4);
      else pass_count++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    mode = 2'd0; out_ready = 1'b0;
    in_value = 32'd7; in_valid = 1'b1;
    tick(); tick();
    rst = 1'b1; out_ready = 1'b1;
    tick();
    check_count++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_value !== 32'd0)
      $display("FAIL rstmid got v=%0b rdy=%0b val=%0d want 0 1 0", out_valid, in_ready, out_value);
    else pass_count++;
    rst = 1'b0; mode = 2'd1; in_value = 32'hFFFF_FFF9;
    tick();
    check_count++;
    if (out_valid !== 1'b1 || out_value !== 32'd0 || out_index !== 32'd0)
      $display("FAIL rstmid_next got v=%0b val=%0d idx=%0d want 1 0 0",
               out_valid, $signed(out_value), out_index);
    else pass_count++;
    in_valid = 1'b0;
    tick();
  endtask

`ifdef ACTIVATION_STATS_EN
  task automatic test_stats;
    int vin[3] = '{-1, 2, -3};
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 2'd1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_value = 32'(vin[i]); in_valid = 1'b1;
      tick();
    end
    check_count++;
    if (clip_count !== 32'd2) $display("FAIL stats_count got %0d want 2", clip_count);
    else pass_count++;
    in_value = 32'hFFFF_FFFB; stats_clear = 1'b1;
    tick();
    check_count++;
    if (clip_count !== 32'd0) $display("FAIL stats_clear got %0d want 0", clip_count);
    else pass_count++;
    stats_clear = 1'b0; in_valid = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_relu();
    test_clamp_leaky();
    test_back_to_back();
    test_mode_switch();
    test_reset_mid();
`ifdef ACTIVATION_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
